// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and defaults for the two-port IO memory arbiter.
//   state_t     : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   DATA_W_DEF  : default data width, matches the IO memory word
//   RD_LAT_DEF  : default memory read latency in clock edges (legal 1..7)
//   CNT_W       : width of the read-latency counter (holds up to 7)
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_DEF = 1;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/io_arb_picker.sv
// io_arb_picker: chooses which requester is granted next.
//   CLK, RST    : clock, synchronous active-high reset
//   req0_valid  : port 0 request pending
//   req1_valid  : port 1 request pending
//   take        : the sequencer commits to 'winner' this cycle
//   any_valid   : at least one request pending
//   winner      : port to grant (0 or 1); meaningful only when any_valid
// Build option IO_ARB_FIXED_PRIO_EN: when defined, port 0 always wins a
// conflict (port 1 may starve); otherwise conflicts are resolved round-robin
// against last_grant, which resets to 1 so port 0 wins the first conflict.
module io_arb_picker (
    input  logic CLK,
    input  logic RST,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic take,
    output logic any_valid,
    output logic winner
);

    logic last_grant;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= winner;
        end
    end

    assign any_valid = req0_valid | req1_valid;

    // With no request pending the winner is a don't-care; last_grant is
    // reused there only so the output has a defined value.
`ifdef IO_ARB_FIXED_PRIO_EN
    always_comb begin
        if (req0_valid) begin
            winner = 1'b0;
        end else if (req1_valid) begin
            winner = 1'b1;
        end else begin
            winner = last_grant;
        end
    end
`else
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end else if (req0_valid) begin
            winner = 1'b0;
        end else begin
            winner = last_grant;
        end
    end
`endif

endmodule

// File: rtl/io_mem_arbiter.sv
// io_mem_arbiter: shares a single-word IO memory between two requesters.
// One transaction at a time: grant, one-cycle enable strobe, wait RD_LAT
// edges for read data, one-cycle completion pulse, back to idle.
// Optional build macro IO_ARB_FIXED_PRIO_EN (handled in io_arb_picker).
// Ports:
//   CLK, RST                      : clock, synchronous active-high reset
//   reqN_valid/we/wdata           : request from port N (N = 0, 1)
//   reqN_ready/rvalid/rdata       : completion pulse, read flag, read data
//   mem_in/mem_write_en/mem_read_en : drive the memory block
//   mem_out                       : memory read data
//   busy                          : high whenever the sequencer is not idle
//   dbg_state                     : current sequencer state (state_t encoding)
// Handshake: a requester raises reqN_valid with reqN_we/reqN_wdata stable and
// holds them until reqN_ready pulses for one cycle; that pulse ends the
// transaction (reqN_rvalid accompanies it on reads). The request is latched
// at grant, so late changes by the requester do not affect the transaction.
// All outputs are registered: each *_d below is the value for next cycle.
module io_mem_arbiter
    import io_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic [DATA_W-1:0]  mem_in_d;
    logic               mem_write_en_d, mem_read_en_d;
    logic               req0_ready_d, req0_rvalid_d, req1_ready_d, req1_rvalid_d;
    logic [DATA_W-1:0]  req0_rdata_d, req1_rdata_d;
    logic               busy_d;

    logic               any_valid, winner, grant_take;
    logic               sel_we;
    logic [DATA_W-1:0]  sel_wdata;

    io_arb_picker u_picker (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .take       (grant_take),
        .any_valid  (any_valid),
        .winner     (winner)
    );

    assign sel_we    = winner ? req1_we    : req0_we;
    assign sel_wdata = winner ? req1_wdata : req0_wdata;
    assign dbg_state = state_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        grant_take     = 1'b0;
        mem_in_d       = mem_in;
        mem_write_en_d = 1'b0;
        mem_read_en_d  = 1'b0;
        req0_ready_d   = 1'b0;
        req0_rvalid_d  = 1'b0;
        req1_ready_d   = 1'b0;
        req1_rvalid_d  = 1'b0;
        req0_rdata_d   = req0_rdata;
        req1_rdata_d   = req1_rdata;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_take     = 1'b1;
                    grant_d        = winner;
                    we_d           = sel_we;
                    wdata_d        = sel_wdata;
                    // Enables are registered, so they are set on entry to ISSUE.
                    mem_in_d       = sel_wdata;
                    mem_write_en_d = sel_we;
                    mem_read_en_d  = ~sel_we;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    req0_ready_d = ~grant_q;
                    req1_ready_d = grant_q;
                    state_d      = DONE;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    if (grant_q) begin
                        req1_rdata_d  = mem_out;
                        req1_ready_d  = 1'b1;
                        req1_rvalid_d = 1'b1;
                    end else begin
                        req0_rdata_d  = mem_out;
                        req0_ready_d  = 1'b1;
                        req0_rvalid_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mem_in       <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            req0_ready   <= 1'b0;
            req0_rvalid  <= 1'b0;
            req0_rdata   <= '0;
            req1_ready   <= 1'b0;
            req1_rvalid  <= 1'b0;
            req1_rdata   <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mem_in       <= mem_in_d;
            mem_write_en <= mem_write_en_d;
            mem_read_en  <= mem_read_en_d;
            req0_ready   <= req0_ready_d;
            req0_rvalid  <= req0_rvalid_d;
            req0_rdata   <= req0_rdata_d;
            req1_ready   <= req1_ready_d;
            req1_rvalid  <= req1_rvalid_d;
            req1_rdata   <= req1_rdata_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: doc/io_mem_arbiter.md
Name: io_mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-word IO memory register block (16-bit MEM_IN/MEM_OUT, read_en/write_en strobes).
- Shares the block between two requesters, e.g. a CPU port (0) and a DMA port (1), using valid/ready handshakes.
- Issues exactly one one-cycle enable strobe per transaction, waits the memory's read latency, and returns read data to the winning requester.

Parameters:
- DATA_W, 16, width of data paths; must match the memory word.
- RD_LAT, 1, number of clock edges from the memory enable strobe until mem_out holds valid data; legal range 1..7.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- req0_valid  in  1  port 0 request; held high until req0_ready.
- req0_we  in  1  port 0 op: 1 = write, 0 = read; stable while valid.
- req0_wdata  in  DATA_W  port 0 write data; stable while valid.
- req0_ready  out  1  one-cycle completion pulse for port 0.
- req0_rvalid  out  1  high with req0_ready on read completion only.
- req0_rdata  out  DATA_W  port 0 read data, held until the next port 0 read completes.
- req1_valid, req1_we, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as port 0, for port 1.
- mem_in  out  DATA_W  drives memory MEM_IN.
- mem_write_en  out  1  drives memory write_en.
- mem_read_en  out  1  drives memory read_en.
- mem_out  in  DATA_W  from memory MEM_OUT.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Single clock CLK; reset RST is synchronous and active-high. All outputs are registered.
- Reset values:
  - all ready/rvalid/enable outputs 0; rdata 0; mem_in 0; busy 0.
  - state IDLE; last_grant = 1, so port 0 wins the first conflict.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any valid is high, select a winner. One valid: that port. Both valid: the port != last_grant.
  - Latch grant, we and wdata; update last_grant; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_write_en = we, mem_read_en = !we, mem_in = latched wdata.
  - Write: go to DONE. Read: go to WAIT with counter = 1.
- WAIT:
  - Enables low.
  - When counter == RD_LAT, capture mem_out into the granted port's rdata register at that edge and go to DONE. Otherwise increment the counter.
- DONE (1 cycle):
  - ready for the granted port = 1; rvalid = 1 if read.
  - Go to IDLE. A new grant is possible in the following IDLE cycle; no back-to-back overlap.
- Latency, valid first sampled at cycle 0:
  - write: enable at cycle 1, ready at cycle 2.
  - read: read_en at cycle 1, ready/rvalid at cycle 2+RD_LAT.
- Invariants:
  - mem_write_en and mem_read_en are never high together.
  - Never more than one ready high per cycle.
  - The other port's outputs stay 0 during a transaction.
- Requester dropping valid or changing we/wdata before ready is illegal. The controller completes using the latched copy.
- Memory write-side MEM_OUT update (old word appears on a write) is ignored. mem_out is only sampled in WAIT.
- Reset asserted mid-transaction: next cycle is IDLE with reset values. An aborted transaction produces no ready.
- Both valid continuously: grants strictly alternate 0, 1, 0, 1...

Optional Feature:
- Macro IO_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a conflict; last_grant is not used for arbitration. Port 1 can starve; this is intentional for CPU-priority builds.
- Undefined: round-robin as above.

Decomposition:
- Package io_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE), DATA_W default, RD_LAT default, latency-counter width constant (3 bits).
- One natural sub-module, io_arb_picker: holds the last_grant register and computes the winner. It owns the IO_ARB_FIXED_PRIO_EN conditional, so the FSM is identical in both builds.

Test Plan:
- RST high for 2 cycles mid-read, then low -> all outputs 0, busy 0, no ready pulse; the next port 0 read proceeds normally.
- Port 0 write 16'hA5A5, then port 0 read, RD_LAT=1 -> write ready at cycle 2; read_en 1 cycle; req0_ready=req0_rvalid=1 at cycle 3, req0_rdata=16'hA5A5.
- Port 1 write 16'h1234, then port 0 read -> req0_rdata=16'h1234; req1_rdata stays 0.
- Both valid continuously, 6 writes each with distinct data -> grants alternate 0,1,0,1...; never both enables high; never both readys high.
- RD_LAT=3 rebuild, port 1 read after writing 16'hBEEF -> ready at cycle 5; rdata=16'hBEEF; mem_out ignored before WAIT count 3.
- IO_ARB_FIXED_PRIO_EN defined, both valid for 4 transactions -> all 4 granted to port 0; port 1 is served once port 0 drops valid.
